// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation best-match tracker:
// default widths/offset and the IDLE/TRACK state encoding.
package me_pkg;

    localparam int SAD_W_DEF  = 16;
    localparam int MV_W_DEF   = 5;
    localparam int MV_OFS_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } me_state_e;

endpackage

// File: rtl/sad_min_cell.sv
// Compare-and-hold cell: keeps the running minimum SAD and the (col,row)
// index where it was seen. The next-state values are exported so the
// parent can publish a result that includes the candidate of this cycle.
module sad_min_cell #(
    parameter int SAD_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             update_i,
    input  logic [SAD_W-1:0] sad_i,
    input  logic [IDX_W-1:0] col_i,
    input  logic [IDX_W-1:0] row_i,
    output logic [SAD_W-1:0] min_sad_o,
    output logic [IDX_W-1:0] min_col_o,
    output logic [IDX_W-1:0] min_row_o
);

    logic [SAD_W-1:0] minSad_q, minSad_d;
    logic [IDX_W-1:0] minCol_q, minCol_d;
    logic [IDX_W-1:0] minRow_q, minRow_d;

    // First candidate loads unconditionally; later ones replace only when strictly smaller so ties keep the earlier index
    always_comb begin
        minSad_d = minSad_q;
        minCol_d = minCol_q;
        minRow_d = minRow_q;
        if (load_i || (update_i && (sad_i < minSad_q))) begin
            minSad_d = sad_i;
            minCol_d = col_i;
            minRow_d = row_i;
        end
    end

    // Running-minimum register; a search restart returns it to the empty value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            minSad_q <= '1;
            minCol_q <= '0;
            minRow_q <= '0;
        end else if (clear_i) begin
            minSad_q <= '1;
            minCol_q <= '0;
            minRow_q <= '0;
        end else begin
            minSad_q <= minSad_d;
            minCol_q <= minCol_d;
            minRow_q <= minRow_d;
        end
    end

    assign min_sad_o = minSad_d;
    assign min_col_o = minCol_d;
    assign min_row_o = minRow_d;

endmodule

// File: rtl/me_best_match.sv
// Best-match tracker for a full-search motion estimator. Scans candidate
// SADs in raster order, tracks the minimum and publishes it (with its
// signed motion vector and candidate count) on a controller refresh.
module me_best_match
    import me_pkg::*;
#(
    parameter int SAD_W  = SAD_W_DEF,
    parameter int N_COL  = 16,
    parameter int N_ROW  = 16,
    parameter int MV_OFS = MV_OFS_DEF,
    parameter int MV_W   = MV_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             compare_work,
    input  logic             compare_refresh,
    input  logic [SAD_W-1:0] sad_in,
    input  logic             result_ack,
    output logic             result_valid,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mvx,
    output logic [MV_W-1:0]  best_mvy,
    output logic [8:0]       cand_count,
    output logic             overrun
);

    localparam int IDX_MAX = (N_COL > N_ROW) ? N_COL : N_ROW;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam logic [8:0]       CAND_MAX = 9'(N_COL * N_ROW);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(N_COL - 1);
    localparam logic [MV_W-1:0]  OFS_T    = MV_W'(MV_OFS);

    me_state_e        state_q, state_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [8:0]       count_q, count_d;

    logic [IDX_W-1:0] candCol, candRow;
    logic             cellLoad, cellUpdate;
    logic             publish, ignoredWork;
    logic [8:0]       pubCount;

    logic [SAD_W-1:0] minSadNext;
    logic [IDX_W-1:0] minColNext, minRowNext;

    logic             valid_q, valid_d;
    logic [SAD_W-1:0] bestSad_q, bestSad_d;
    logic [MV_W-1:0]  mvx_q, mvx_d;
    logic [MV_W-1:0]  mvy_q, mvy_d;
    logic [8:0]       candCount_q, candCount_d;
    logic             overrun_q, overrun_d;

    sad_min_cell #(
        .SAD_W (SAD_W),
        .IDX_W (IDX_W)
    ) u_min_cell (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (publish),
        .load_i    (cellLoad),
        .update_i  (cellUpdate),
        .sad_i     (sad_in),
        .col_i     (candCol),
        .row_i     (candRow),
        .min_sad_o (minSadNext),
        .min_col_o (minColNext),
        .min_row_o (minRowNext)
    );

    // Search control: raster index advance, candidate counting, saturation and the publish decision
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        count_d     = count_q;
        candCol     = '0;
        candRow     = '0;
        cellLoad    = 1'b0;
        cellUpdate  = 1'b0;
        publish     = 1'b0;
        ignoredWork = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (compare_work) begin
                    cellLoad = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    count_d  = 9'd1;
                    state_d  = ST_TRACK;
                    publish  = compare_refresh;
                end
            end
            ST_TRACK: begin
                if (compare_work) begin
                    if (count_q == CAND_MAX) begin
                        ignoredWork = 1'b1;
                    end else begin
                        if (col_q == COL_LAST) begin
                            candCol = '0;
                            candRow = row_q + IDX_W'(1);
                        end else begin
                            candCol = col_q + IDX_W'(1);
                            candRow = row_q;
                        end
                        cellUpdate = 1'b1;
                        col_d      = candCol;
                        row_d      = candRow;
                        count_d    = count_q + 9'd1;
                    end
                end
                publish = compare_refresh;
            end
            default: state_d = ST_IDLE;
        endcase
        pubCount = count_d;
        if (publish) begin
            state_d = ST_IDLE;
            col_d   = '0;
            row_d   = '0;
            count_d = '0;
        end
    end

    // Result holding: publish overwrites (and flags an unacked overwrite), ack clears valid, overflow is sticky
    always_comb begin
        valid_d     = valid_q;
        bestSad_d   = bestSad_q;
        mvx_d       = mvx_q;
        mvy_d       = mvy_q;
        candCount_d = candCount_q;
        overrun_d   = overrun_q;
        if (publish) begin
            valid_d     = 1'b1;
            bestSad_d   = minSadNext;
            mvx_d       = MV_W'(minColNext) - OFS_T;
            mvy_d       = MV_W'(minRowNext) - OFS_T;
            candCount_d = pubCount;
            if (valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end else if (result_ack) begin
            valid_d = 1'b0;
        end
        if (ignoredWork) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            bestSad_q   <= '1;
            mvx_q       <= '0;
            mvy_q       <= '0;
            candCount_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            bestSad_q   <= bestSad_d;
            mvx_q       <= mvx_d;
            mvy_q       <= mvy_d;
            candCount_q <= candCount_d;
            overrun_q   <= overrun_d;
        end
    end

    assign result_valid = valid_q;
    assign best_sad     = bestSad_q;
    assign best_mvx     = mvx_q;
    assign best_mvy     = mvy_q;
    assign cand_count   = candCount_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_me_best_match.sv
// Directed self-checking bench for me_best_match with default parameters
// (16x16 candidates, vector offset 8, 5-bit vectors).
module tb_me_best_match;

    logic        clk;
    logic        resetn;
    logic        compare_work;
    logic        compare_refresh;
    logic [15:0] sad_in;
    logic        result_ack;
    logic        result_valid;
    logic [15:0] best_sad;
    logic [4:0]  best_mvx;
    logic [4:0]  best_mvy;
    logic [8:0]  cand_count;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    me_best_match dut (
        .clk             (clk),
        .resetn          (resetn),
        .compare_work    (compare_work),
        .compare_refresh (compare_refresh),
        .sad_in          (sad_in),
        .result_ack      (result_ack),
        .result_valid    (result_valid),
        .best_sad        (best_sad),
        .best_mvx        (best_mvx),
        .best_mvy        (best_mvy),
        .cand_count      (cand_count),
        .overrun         (overrun)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, let the edge happen, then release the strobes
    task automatic applyStimulus(input logic w, input logic r, input logic a, input logic [15:0] s);
        compare_work    = w;
        compare_refresh = r;
        result_ack      = a;
        sad_in          = s;
        @(posedge clk);
        #1;
        compare_work    = 1'b0;
        compare_refresh = 1'b0;
        result_ack      = 1'b0;
        sad_in          = '0;
    endtask

    // Check the full published result in one go
    task automatic checkResult(input string tag, input logic v, input logic [15:0] s,
                               input logic [4:0] mx, input logic [4:0] my,
                               input logic [8:0] n, input logic ov);
        checkOutput({tag, ".valid"}, 32'(result_valid), 32'(v));
        checkOutput({tag, ".sad"}, 32'(best_sad), 32'(s));
        checkOutput({tag, ".mvx"}, 32'(best_mvx), 32'(mx));
        checkOutput({tag, ".mvy"}, 32'(best_mvy), 32'(my));
        checkOutput({tag, ".count"}, 32'(cand_count), 32'(n));
        checkOutput({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    // Stimulus sequence
    initial begin
        resetn          = 1'b0;
        compare_work    = 1'b0;
        compare_refresh = 1'b0;
        result_ack      = 1'b0;
        sad_in          = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResult("reset", 1'b0, 16'hFFFF, 5'd0, 5'd0, 9'd0, 1'b0);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Full search, single minimum 37 at col=3,row=5 -> (-5,-3)
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, (i == 5 * 16 + 3) ? 16'd37 : 16'd1000);
        end
        checkOutput("min.noEarlyValid", 32'(result_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkResult("min", 1'b1, 16'd37, 5'h1B, 5'h1D, 9'd256, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
        checkOutput("min.ackClears", 32'(result_valid), 32'd0);
        checkOutput("min.sadHeld", 32'(best_sad), 32'd37);

        // Tie: 50 at col=2,row=0 and col=9,row=4; earlier wins -> (-6,-8)
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, (i == 2 || i == 4 * 16 + 9) ? 16'd50 : 16'd99);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkResult("tie", 1'b1, 16'd50, 5'h1A, 5'h18, 9'd256, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);

        // Last candidate (col=15,row=15) carries 0 and coincides with refresh -> (7,7)
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'd500);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0);
        checkResult("coinc", 1'b1, 16'd0, 5'd7, 5'd7, 9'd256, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);

        // 257th candidate is ignored and flags overrun; first candidate wins -> (-8,-8)
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'd700);
        end
        checkOutput("sat.noOverrunAtFull", 32'(overrun), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1);
        checkOutput("sat.overrun", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkResult("sat", 1'b1, 16'd700, 5'h18, 5'h18, 9'd256, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("idleRefresh.valid", 32'(result_valid), 32'd0);
        checkOutput("idleRefresh.sad", 32'(best_sad), 32'd700);

        // Asynchronous reset after 10 candidates discards the search
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'(20 + i));
        end
        #2 resetn = 1'b0;
        #1;
        checkResult("midReset", 1'b0, 16'hFFFF, 5'd0, 5'd0, 9'd0, 1'b0);
        #2 resetn = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkOutput("midReset.noResult", 32'(result_valid), 32'd0);

        // Two publishes without ack: second overwrites and sets overrun
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd20);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkResult("pubA", 1'b1, 16'd5, 5'h19, 5'h18, 9'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd30);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd40);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
        checkResult("pubB", 1'b1, 16'd30, 5'h18, 5'h18, 9'd2, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
        checkOutput("pubB.ackClears", 32'(result_valid), 32'd0);
        checkOutput("pubB.overrunSticky", 32'(overrun), 32'd1);
        checkOutput("pubB.sadHeld", 32'(best_sad), 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_best_match.md
ME_BEST_MATCH -- requirements
Module: me_best_match

Interface
REQ-001 SHALL have parameter SAD_W, default 16, width of SAD input and best_sad.
REQ-002 SHALL have parameter N_COL, default 16, candidate columns per search row.
REQ-003 SHALL have parameter N_ROW, default 16, candidate rows per search.
REQ-004 SHALL have parameter MV_OFS, default 8, offset subtracted from column/row index to form a signed vector.
REQ-005 SHALL have parameter MV_W, default 5, two's-complement width of best_mvx/best_mvy.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port compare_work  input  1  controller strobe: sad_in is a valid candidate this cycle.
REQ-009 SHALL have port compare_refresh  input  1  controller strobe: close current search, publish result, restart.
REQ-010 SHALL have port sad_in  input  SAD_W  SAD of current candidate from PE array.
REQ-011 SHALL have port result_ack  input  1  consumer acknowledges held result.
REQ-012 SHALL have port result_valid  output  1  published result held on best_* outputs.
REQ-013 SHALL have port best_sad  output  SAD_W  minimum SAD of last published search.
REQ-014 SHALL have port best_mvx, best_mvy  output  MV_W each  signed vector of minimum (col-MV_OFS, row-MV_OFS).
REQ-015 SHALL have port cand_count  output  9  number of candidates in last published search.
REQ-016 SHALL have port overrun  output  1  sticky: a result was overwritten before ack, or candidates exceeded N_COL*N_ROW.

Function
REQ-017 SHALL run FSM IDLE (no candidate since last restart) and TRACK (>=1 candidate accepted).
REQ-018 SHALL in IDLE on compare_work load running min = sad_in, index col=0,row=0, count=1, go TRACK.
REQ-019 SHALL in TRACK on compare_work advance col; col wraps N_COL-1 -> 0 with row+1; replace running min and its (col,row) only if sad_in strictly less (ties keep earlier candidate).
REQ-020 SHALL, when count already equals N_COL*N_ROW, ignore further compare_work and set overrun.
REQ-021 SHALL on compare_refresh in TRACK latch running min, vector and count into output registers, assert result_valid next cycle, return to IDLE.
REQ-022 SHALL, when compare_work and compare_refresh coincide, include that cycle's sad_in in the published result before restarting.
REQ-023 SHALL ignore compare_refresh in IDLE (no result, outputs unchanged).
REQ-024 SHALL hold result_valid and best_* stable until result_ack sampled high; result_valid clears the following cycle.
REQ-025 SHALL, if a new publish occurs while result_valid is high and unacked, overwrite best_*, keep result_valid high, set overrun; publish wins over a same-cycle ack.
REQ-026 SHALL compute vectors as index minus MV_OFS truncated to MV_W signed bits; N_COL,N_ROW <= 2**(MV_W-1)+MV_OFS.
REQ-027 SHALL have latency 1 clock from sampled compare_refresh edge to result_valid high.

Reset
REQ-028 SHALL on resetn low asynchronously force IDLE, result_valid=0, best_sad=all ones, best_mvx=best_mvy=0, cand_count=0, overrun=0, running min/index/count cleared.
REQ-029 SHALL on reset mid-search discard the partial search with no result published; overrun clears only on reset.

Structure
REQ-030 SHALL place SAD_W, MV_W, MV_OFS defaults and the IDLE/TRACK state encoding in shared package me_pkg.
REQ-031 SHALL implement the compare-and-hold of running min plus index as one sub-module, sad_min_cell.

Verification
REQ-032 SHALL check: 256 compare_work with sad_in=1000 except 37 at index col=3,row=5, then refresh -> result_valid, best_sad=37, mvx=-5, mvy=-3, cand_count=256.
REQ-033 SHALL check tie: sad 50 at col=2,row=0 and col=9,row=4 (others 99) -> mvx=-6, mvy=-8.
REQ-034 SHALL check coincident work+refresh with final sad_in=0 at last candidate -> best_sad=0, mvx=7, mvy=7.
REQ-035 SHALL check two publishes without ack -> overrun=1, best_* from second search; then ack -> result_valid low next cycle, overrun stays 1.
REQ-036 SHALL check 257th compare_work -> ignored, overrun=1, cand_count=256 on publish; refresh in IDLE -> no result_valid.
REQ-037 SHALL check resetn low mid-search after 10 candidates -> all outputs at reset values immediately, subsequent refresh produces no result.
